// File: rtl/aes_sbox_seq_pkg.sv
// aes_sbox_seq_pkg
// Shared types, field constants and helper functions for the iterative AES
// S-box unit.
//   - FSM state enum (SBOX_IDLE .. SBOX_DONE, 3-bit binary)
//   - GF(2^4) arithmetic modulo x^4+x+1, lambda for GF((2^4)^2) = y^2+y+lambda
//   - isomorphic map delta (AES field -> composite field) and its inverse
//   - forward / inverse AES affine transforms
// The delta matrices are derived at elaboration time from the field
// definitions, so they are always consistent with LAMBDA and the GF(2^4)
// polynomial.
package aes_sbox_seq_pkg;

  typedef enum logic [2:0] {
    SBOX_IDLE = 3'd0,
    SBOX_MUL0 = 3'd1,
    SBOX_MUL1 = 3'd2,
    SBOX_MUL2 = 3'd3,
    SBOX_DONE = 3'd4
  } sbox_state_e;

  // x^4 reduces to x + 1.
  localparam logic [3:0] GF4_RED     = 4'h3;
  // Trace(0xE) = 1, so y^2 + y + 0xE is irreducible over GF(2^4).
  localparam logic [3:0] LAMBDA      = 4'hE;
  localparam logic [7:0] AFFINE_C    = 8'h63;
  localparam logic [7:0] INV_AFFINE_C = 8'h05;

  function automatic logic [3:0] gf4_mul(input logic [3:0] a, input logic [3:0] b);
    logic [3:0] p;
    logic [3:0] t;
    p = 4'h0;
    t = a;
    for (int i = 0; i < 4; i++) begin
      if (b[i]) p = p ^ t;
      t = {t[2:0], 1'b0} ^ (t[3] ? GF4_RED : 4'h0);
    end
    return p;
  endfunction

  // Multiply in GF((2^4)^2): element = hi*y + lo, with y^2 = y + LAMBDA.
  function automatic logic [7:0] comp_mul(input logic [7:0] a, input logic [7:0] b);
    logic [3:0] hh;
    logic [3:0] hi;
    logic [3:0] lo;
    hh = gf4_mul(a[7:4], b[7:4]);
    hi = hh ^ gf4_mul(a[7:4], b[3:0]) ^ gf4_mul(a[3:0], b[7:4]);
    lo = gf4_mul(hh, LAMBDA) ^ gf4_mul(a[3:0], b[3:0]);
    return {hi, lo};
  endfunction

  // GF(2)-linear map given as eight 8-bit columns; column i is the image of bit i.
  function automatic logic [7:0] lin_map(input logic [63:0] cols, input logic [7:0] a);
    logic [7:0] r;
    r = 8'h00;
    for (int i = 0; i < 8; i++) begin
      if (a[i]) r = r ^ cols[i*8 +: 8];
    end
    return r;
  endfunction

  // Smallest composite-field root of the AES polynomial x^8+x^4+x^3+x+1.
  function automatic logic [7:0] find_beta(input logic [7:0] start);
    logic [7:0] b;
    logic [7:0] b2;
    logic [7:0] b4;
    logic [7:0] b8;
    logic [7:0] b3;
    logic [7:0] r;
    r = 8'h00;
    for (int c = 0; c < 256; c++) begin
      b  = start + 8'(c);
      b2 = comp_mul(b, b);
      b4 = comp_mul(b2, b2);
      b8 = comp_mul(b4, b4);
      b3 = comp_mul(b2, b);
      if (r == 8'h00 && b > 8'h01 && (b8 ^ b4 ^ b3 ^ b ^ 8'h01) == 8'h00) r = b;
    end
    return r;
  endfunction

  // delta maps x^i of the AES field onto beta^i.
  function automatic logic [63:0] calc_delta(input logic [7:0] beta);
    logic [63:0] cols;
    logic [7:0]  pw;
    cols = 64'h0;
    pw   = 8'h01;
    for (int i = 0; i < 8; i++) begin
      cols[i*8 +: 8] = pw;
      pw = comp_mul(pw, beta);
    end
    return cols;
  endfunction

  // Column j of delta^-1 is the byte that delta sends to the unit vector j.
  function automatic logic [63:0] calc_delta_inv(input logic [63:0] fwd);
    logic [63:0] cols;
    cols = 64'h0;
    for (int j = 0; j < 8; j++) begin
      for (int c = 0; c < 256; c++) begin
        if (lin_map(fwd, 8'(c)) == (8'h01 << j)) cols[j*8 +: 8] = 8'(c);
      end
    end
    return cols;
  endfunction

  localparam logic [7:0]  BETA       = find_beta(8'h00);
  localparam logic [63:0] DELTA      = calc_delta(BETA);
  localparam logic [63:0] DELTA_INV  = calc_delta_inv(DELTA);

  function automatic logic [7:0] delta_map(input logic [7:0] a);
    return lin_map(DELTA, a);
  endfunction

  function automatic logic [7:0] delta_inv_map(input logic [7:0] a);
    return lin_map(DELTA_INV, a);
  endfunction

  // b_i = a_i ^ a_(i+4) ^ a_(i+5) ^ a_(i+6) ^ a_(i+7) ^ c_i, written as rotations.
  function automatic logic [7:0] affine(input logic [7:0] a);
    return a ^ {a[6:0], a[7]} ^ {a[5:0], a[7:6]} ^ {a[4:0], a[7:5]} ^
           {a[3:0], a[7:4]} ^ AFFINE_C;
  endfunction

  // b_i = a_(i+2) ^ a_(i+5) ^ a_(i+7) ^ d_i.
  function automatic logic [7:0] inv_affine(input logic [7:0] a);
    return {a[6:0], a[7]} ^ {a[4:0], a[7:5]} ^ {a[1:0], a[7:2]} ^ INV_AFFINE_C;
  endfunction

endpackage

// File: rtl/gf_inv_4.sv
// gf_inv_4
// Combinational GF(2^4) inverse, modulo x^4+x+1. a^-1 = a^14; 0 maps to 0.
//   a   : 4-bit operand
//   inv : 4-bit inverse
module gf_inv_4
  import aes_sbox_seq_pkg::*;
(
  input  logic [3:0] a,
  output logic [3:0] inv
);

  logic [3:0] a2;
  logic [3:0] a4;
  logic [3:0] a8;

  assign a2  = gf4_mul(a, a);
  assign a4  = gf4_mul(a2, a2);
  assign a8  = gf4_mul(a4, a4);
  assign inv = gf4_mul(gf4_mul(a2, a4), a8);

endmodule

// File: rtl/gf_mul_4.sv
// gf_mul_4
// Combinational GF(2^4) multiplier, modulo x^4+x+1.
//   a, b : 4-bit operands
//   p    : 4-bit product
module gf_mul_4
  import aes_sbox_seq_pkg::*;
(
  input  logic [3:0] a,
  input  logic [3:0] b,
  output logic [3:0] p
);

  assign p = gf4_mul(a, b);

endmodule

// File: rtl/gf_sq_scale_4.sv
// gf_sq_scale_4
// Combinational squarer / lambda-scaler for the composite-field norm.
//   hi, lo : high and low GF(2^4) halves of the operand
//   sq_sum : LAMBDA*hi^2 ^ lo^2
module gf_sq_scale_4
  import aes_sbox_seq_pkg::*;
(
  input  logic [3:0] hi,
  input  logic [3:0] lo,
  output logic [3:0] sq_sum
);

  logic [3:0] hi_sq;
  logic [3:0] lo_sq;

  assign hi_sq  = gf4_mul(hi, hi);
  assign lo_sq  = gf4_mul(lo, lo);
  assign sq_sum = gf4_mul(hi_sq, LAMBDA) ^ lo_sq;

endmodule

// File: rtl/aes_sbox_seq.sv
// aes_sbox_seq
// Iterative AES S-box / inverse S-box, one byte per transaction, computed in
// GF((2^4)^2) with a single shared GF(2^4) multiplier over three cycles.
//
// Handshake: a transfer happens on the rising edge where valid && ready are
// both high. in_ready is high only in IDLE; out_valid is high only in DONE, so
// input and output transfers never coincide. out_data stays stable while
// out_valid is high and out_ready is low.
//
// Ports:
//   clk, rst_n          : clock, synchronous active-low reset
//   in_valid / in_ready : input handshake; in_data is the byte, in_dec picks
//                         inverse S-box (1) or S-box (0)
//   out_valid/out_ready : output handshake; out_data is the substituted byte
//   dbg_state           : current FSM state, for observation only
module aes_sbox_seq
  import aes_sbox_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] in_data,
  input  logic       in_dec,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] out_data,
  output logic [2:0] dbg_state
);

  sbox_state_e state_q, state_d;
  logic [3:0]  ah_q, ah_d;
  logic [3:0]  al_q, al_d;
  logic [3:0]  d_inv_q, d_inv_d;
  logic [3:0]  rh_q, rh_d;
  logic        dec_q, dec_d;
  logic [7:0]  out_data_q, out_data_d;
  logic        out_valid_q, out_valid_d;

  logic [3:0]  mul_a;
  logic [3:0]  mul_b;
  logic [3:0]  mul_p;
  logic [3:0]  sq_sum;
  logic [3:0]  norm;
  logic [3:0]  norm_inv;
  logic [7:0]  mapped;
  logic [7:0]  result;

  gf_mul_4 u_mul (
    .a (mul_a),
    .b (mul_b),
    .p (mul_p)
  );

  gf_sq_scale_4 u_sq (
    .hi     (ah_q),
    .lo     (al_q),
    .sq_sum (sq_sum)
  );

  // Norm d = LAMBDA*ah^2 ^ ah*al ^ al^2; the ah*al term comes from the shared
  // multiplier during MUL0 only.
  assign norm = sq_sum ^ mul_p;

  gf_inv_4 u_inv (
    .a   (norm),
    .inv (norm_inv)
  );

  assign in_ready  = (state_q == SBOX_IDLE);
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign dbg_state = state_q;

  always_comb begin
    state_d     = state_q;
    ah_d        = ah_q;
    al_d        = al_q;
    d_inv_d     = d_inv_q;
    rh_d        = rh_q;
    dec_d       = dec_q;
    out_data_d  = out_data_q;
    out_valid_d = out_valid_q;
    mul_a       = 4'h0;
    mul_b       = 4'h0;
    mapped      = 8'h00;
    result      = 8'h00;

    case (state_q)
      SBOX_IDLE: begin
        if (in_valid) begin
          mapped  = delta_map(in_dec ? inv_affine(in_data) : in_data);
          ah_d    = mapped[7:4];
          al_d    = mapped[3:0];
          dec_d   = in_dec;
          state_d = SBOX_MUL0;
        end
      end
      SBOX_MUL0: begin
        mul_a   = ah_q;
        mul_b   = al_q;
        d_inv_d = norm_inv;
        state_d = SBOX_MUL1;
      end
      SBOX_MUL1: begin
        mul_a   = ah_q;
        mul_b   = d_inv_q;
        rh_d    = mul_p;
        state_d = SBOX_MUL2;
      end
      SBOX_MUL2: begin
        // Low half of the inverse is (ah ^ al) * d^-1.
        mul_a       = ah_q ^ al_q;
        mul_b       = d_inv_q;
        result      = delta_inv_map({rh_q, mul_p});
        out_data_d  = dec_q ? result : affine(result);
        out_valid_d = 1'b1;
        state_d     = SBOX_DONE;
      end
      SBOX_DONE: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = SBOX_IDLE;
        end
      end
      default: begin
        state_d = SBOX_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= SBOX_IDLE;
      ah_q        <= 4'h0;
      al_q        <= 4'h0;
      d_inv_q     <= 4'h0;
      rh_q        <= 4'h0;
      dec_q       <= 1'b0;
      out_data_q  <= 8'h00;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      ah_q        <= ah_d;
      al_q        <= al_d;
      d_inv_q     <= d_inv_d;
      rh_q        <= rh_d;
      dec_q       <= dec_d;
      out_data_q  <= out_data_d;
      out_valid_q <= out_valid_d;
    end
  end

endmodule

// File: doc/aes_sbox_seq.md
# aes_sbox_seq

Iterative AES S-box unit for the area-optimised datapath. It computes SubBytes (encrypt) or InvSubBytes (decrypt) for one byte at a time in the GF((2^4)^2) composite field, time-multiplexing a single `gf_mul_4` instance over three cycles. It sits between the byte-serial state buffer and the ShiftRows/MixColumns stage, consuming `gf_mul_4` products and presenting one substituted byte per transaction through a valid/ready handshake.

## Interface
- No parameters. Field constants come from `aes_types.v`.
- `clk` input 1: single clock, rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `in_valid` input 1: `in_data`/`in_dec` are valid.
- `in_ready` output 1: unit can accept a byte.
- `in_data` input 8: byte to substitute.
- `in_dec` input 1: 0 selects S-box, 1 selects inverse S-box; sampled at accept.
- `out_valid` output 1: `out_data` is valid.
- `out_ready` input 1: consumer takes `out_data`.
- `out_data` output 8: substituted byte.

## Operation
- FSM states: IDLE, MUL0, MUL1, MUL2, DONE. Encoding is binary, 3 bits.
- IDLE:
  - `in_ready`=1.
  - On `in_valid`: latch the operand and go to MUL0.
  - The latched operand is built as follows. If decrypt, apply the inverse affine transform to `in_data` first. Then apply the isomorphic map δ into GF((2^4)^2). Register the result as ah (high nibble) and al (low nibble). Latch `in_dec` as `dec_r`.
- MUL0:
  - Multiplier operands are ah and al.
  - d = λ·ah² ⊕ ah·al ⊕ al², where squarer and λ-scaler are combinational in GF(2^4).
  - Register d_inv = gf_inv_4(d). gf_inv_4 is combinational, with gf_inv_4(0)=0.
  - Go to MUL1.
- MUL1: multiplier operands are ah and d_inv. Register the product as rh. Go to MUL2.
- MUL2:
  - Multiplier operands are (ah⊕al) and d_inv, giving rl.
  - Apply δ⁻¹ to {rh, rl}. If `dec_r`=0, also apply the affine transform (matrix plus 0x63).
  - Register the result into `out_data`, set `out_valid`=1, and go to DONE.
- DONE:
  - Hold `out_valid`=1 and `out_data` stable.
  - On `out_ready`: clear `out_valid` and go to IDLE.
- The multiplier input mux is driven by state. The multiplier output is only consumed in MUL0, MUL1 and MUL2.
- Input 0x00 needs no special case: zero maps to zero through the inversion, giving S(0)=0x63.
- Arithmetic:
  - All GF(2^4) operations are modulo x⁴+x+1.
  - Addition is XOR; no carries.
  - All intermediates are exactly 4 bits.

## Timing
- Reset (`rst_n`=0 at a rising edge) forces the following, regardless of state, including mid-computation. The in-flight byte is discarded with no output:
  - state=IDLE
  - `out_valid`=0
  - `out_data`=0x00
  - `in_ready`=1 on the following cycle
  - ah, al, d_inv, rh, `dec_r` cleared to 0
- `in_ready` is a combinational decode of state==IDLE.
- Accept happens on the edge where `in_valid`&&`in_ready`.
- Latency: `out_valid` rises on the 3rd rising edge after the accept edge.
- Throughput: at most one byte per 5 cycles, reached when `out_ready` is held high.
- Because `in_ready` is 0 in DONE, accept-while-output-pending cannot happen and simultaneous in/out handshakes never occur.
- `in_valid` deasserted in IDLE: the unit stays in IDLE and changes no registers.
- `out_ready` held low: the unit stays in DONE indefinitely with output stable (backpressure).
- `in_data` and `in_dec` are don't-care outside the accept cycle.

## Structure
- `aes_types.v` (shared include) holds:
  - δ and δ⁻¹ matrices
  - λ constant
  - affine matrix and constant 0x63
  - inverse affine matrix and constant 0x05
  - FSM state localparams `SBOX_IDLE`…`SBOX_DONE`
- One sub-module instance: `gf_mul_4`. The squarer/scaler and `gf_inv_4` are existing combinational modules, instantiated once each.
- Map and affine functions are Verilog functions in the include.

## Test plan
- Reset then encrypt, `in_data`=0x00 → `out_data`=0x63 with `out_valid` on the 3rd edge after accept; `in_ready`=0 until DONE completes.
- Encrypt 0x53→0xED, 0x01→0x7C, 0xFF→0x16 back-to-back with `out_ready`=1 → exactly 5 cycles between accepts.
- Decrypt 0xED→0x53, 0x63→0x00, 0x16→0xFF.
- Exhaustive: all 256 bytes encrypt then decrypt round-trip to the original; encrypt results match the FIPS-197 table.
- Backpressure: `out_ready`=0 for 10 cycles in DONE → `out_data` stable, `in_ready`=0, no accept despite `in_valid`=1.
- Reset asserted in MUL1 → next cycle IDLE, `out_valid`=0, `out_data`=0x00; the following byte 0x53 → 0xED correctly.
